// File: rtl/inv_round_linear.sv
// AES decryption round back half: InvShiftRows + AddRoundKey on acceptance,
// then InvMixColumns one column per cycle (skipped on the final round).
module inv_round_linear (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] round_key,
  input  logic         last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  localparam int unsigned NCOL  = 4;
  localparam int unsigned NROW  = 4;
  localparam int unsigned COL_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_nx;
  logic [1:0]    col_q, col_nx;
  logic [0:127]  st_nx;
  logic [0:127]  isr_ark;
  logic [0:31]   mix_in;
  logic [0:31]   mix_out;

  // Multiply by x in GF(2^8) modulo 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns of one column; byte r of the column sits at bits [8r:8r+7]
  function automatic logic [0:31] inv_mix_col(input logic [0:31] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [0:31] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[8*r +: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    res[0:7]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    res[8:15]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    res[16:23] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    res[24:31] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return res;
  endfunction

  // InvShiftRows of the incoming state followed by AddRoundKey
  always_comb begin
    isr_ark = '0;
    for (int c = 0; c < int'(NCOL); c++) begin
      for (int r = 0; r < int'(NROW); r++) begin
        isr_ark[BYTE_W*(NROW*c + r) +: BYTE_W] =
          in_state[BYTE_W*(NROW*((c - r + 4) % 4) + r) +: BYTE_W] ^
          round_key[BYTE_W*(NROW*c + r) +: BYTE_W];
      end
    end
  end

  // Select the column addressed by the column counter and mix it
  always_comb begin
    mix_in = '0;
    for (int c = 0; c < int'(NCOL); c++) begin
      if (col_q == 2'(c)) mix_in = out_state[COL_W*c +: COL_W];
    end
    mix_out = inv_mix_col(mix_in);
  end

  // Next-state, column counter and state-register update
  always_comb begin
    state_nx = state_q;
    col_nx   = col_q;
    st_nx    = out_state;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_nx    = isr_ark;
          col_nx   = 2'd0;
          state_nx = last ? DONE : MIX;
        end
      end
      MIX: begin
        for (int c = 0; c < int'(NCOL); c++) begin
          if (col_q == 2'(c)) st_nx[COL_W*c +: COL_W] = mix_out;
        end
        col_nx = col_q + 2'd1;
        if (col_q == 2'd3) state_nx = DONE;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus registered handshake/status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= 2'd0;
      out_state <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_nx;
      col_q     <= col_nx;
      out_state <= st_nx;
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_inv_round_linear.sv
// Directed + randomized bench for inv_round_linear with a byte-array model.
module tb_inv_round_linear;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic [0:127] round_key;
  logic         last;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;
  logic         busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  inv_round_linear dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .round_key (round_key),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shift-and-add multiplication in GF(2^8), polynomial 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Reference round: rows of the matrix are rotations of {0e 0b 0d 09}
  function automatic logic [0:127] model(input logic [0:127] st, input logic [0:127] key, input logic l);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [0:127] res;
    int           c, r;
    m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    for (int b = 0; b < 16; b++) begin
      c = b / 4;
      r = b % 4;
      s[b] = st[8*(4*((c - r + 4) % 4) + r) +: 8] ^ key[8*b +: 8];
    end
    for (int b = 0; b < 16; b++) begin
      c = b / 4;
      r = b % 4;
      if (l) t[b] = s[b];
      else begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(m[(k - r + 4) % 4], s[4*c + k]);
        t[b] = acc;
      end
    end
    for (int b = 0; b < 16; b++) res[8*b +: 8] = t[b];
    return res;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one block through with consumer stalled until out_valid is seen
  task automatic run_block(input string tag, input logic [0:127] din, input logic [0:127] key,
                           input logic l, output logic [0:127] got);
    int lat;
    in_state  = din;
    round_key = key;
    last      = l;
    in_valid  = 1'b1;
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    step();
    in_valid  = 1'b0;
    in_state  = rnd128();
    round_key = rnd128();
    last      = $urandom_range(0, 1) == 1;
    lat = 1;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), l ? 128'(1) : 128'(5));
    got = out_state;
    check({tag, "_model"}, got, model(din, key, l));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_release"}, 128'({out_valid, busy, in_ready}), 128'(3'b001));
  endtask

  initial begin
    logic [0:127] got, hold, d1, d2, k1, k2;
    logic [0:127] q[$];
    int           last_acc, blip;
    logic         prev_ov, lr;

    // Reset, with in_valid high to show it is ignored
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; last = 1'b0;
    in_state = rnd128(); round_key = rnd128();
    step(); step();
    rst = 1'b0; in_valid = 1'b0;
    check("reset_flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    check("reset_state", out_state, 128'h0);

    // InvShiftRows only
    for (int b = 0; b < 16; b++) d1[8*b +: 8] = 8'(b);
    run_block("isr", d1, 128'h0, 1'b1, got);
    check("isr_const", got, 128'h000d0a07_04010e0b_0805020f_0c090603);

    // InvMixColumns known vectors
    run_block("imc1", {4{32'h8e4da1bc}}, 128'h0, 1'b0, got);
    check("imc1_const", got, {4{32'hdb135345}});
    run_block("imc2", {4{32'h9fdc589d}}, 128'h0, 1'b0, got);
    check("imc2_const", got, {4{32'hf20a225c}});
    run_block("imc3", {4{32'hc6c6c6c6}}, {4{32'hffffffff}}, 1'b0, got);
    check("imc3_const", got, {4{32'h39393939}});

    // Random blocks, random final-round flag
    for (int i = 0; i < 16; i++) begin
      lr = $urandom_range(0, 1) == 1;
      run_block("rand", rnd128(), rnd128(), lr, got);
    end

    // Backpressure: hold DONE for 10 cycles, then release and accept at once
    d1 = rnd128(); k1 = rnd128();
    run_block("bp_warm", d1, k1, 1'b0, got);
    in_state = d1; round_key = k1; last = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    blip = 0;
    while (!out_valid && blip < 30) begin step(); blip++; end
    check("bp_reach_done", 128'(out_valid), 128'(1));
    hold = out_state;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {125'(0), out_valid, in_ready, (out_state === hold)}, 128'(3'b101));
      step();
    end
    check("bp_value", out_state, model(d1, k1, 1'b0));
    d2 = rnd128(); k2 = rnd128();
    in_state = d2; round_key = k2; last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    step();
    in_valid = 1'b0;
    check("bp_second", {127'(0), out_valid}, 128'(1));
    check("bp_second_val", out_state, model(d2, k2, 1'b1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during MIX column 2 discards the block
    in_state = rnd128(); round_key = rnd128(); last = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_flags", 128'({out_valid, busy, in_ready}), 128'(3'b001));
    check("mrst_state", out_state, 128'h0);
    blip = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) blip++;
      step();
    end
    check("mrst_no_pulse", 128'(blip), 128'(0));
    run_block("mrst_after", rnd128(), rnd128(), 1'b1, got);

    // Continuous in_valid with out_ready high
    last_acc = -1;
    prev_ov  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_state = rnd128(); round_key = rnd128(); last = 1'b0; in_valid = 1'b1;
      if (out_valid) begin
        check("proto_pulse", 128'(prev_ov), 128'(0));
        if (q.size() > 0) check("proto_data", out_state, q.pop_front());
        else check("proto_unexpected", 128'(1), 128'(0));
      end
      if (in_ready) begin
        check("proto_idle_busy", 128'(busy), 128'(0));
        if (last_acc >= 0) check("proto_spacing", 128'(cyc - last_acc), 128'(6));
        last_acc = cyc;
        q.push_back(model(in_state, round_key, 1'b0));
      end
      prev_ov = out_valid;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && q.size() > 0) check("proto_drain", out_state, q.pop_front());
      step();
    end
    check("proto_empty", 128'(q.size()), 128'(0));
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_round_linear.md
INV_ROUND_LINEAR -- requirements
Module: inv_round_linear

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_state, round_key and last are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: the block can accept a state.
REQ-005 SHALL have port in_state, input, [0:127]: AES state, already passed through InvSubBytes, column-major; byte b = 4*c + r occupies bits [8b:8b+7].
REQ-006 SHALL have port round_key, input, [0:127]: round key, same byte layout as in_state.
REQ-007 SHALL have port last, input, 1 bit: final decryption round, so InvMixColumns is skipped.
REQ-008 SHALL have port out_valid, output, 1 bit: out_state holds a result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts out_state.
REQ-010 SHALL have port out_state, output, [0:127]: result state, same byte layout as in_state.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement InvShiftRows as out(r,c) = in(r,(c-r) mod 4); rows are not rotated at r=0, rotated by 1 column at r=1, 2 at r=2, 3 at r=3.
REQ-013 SHALL, on acceptance (in_valid && in_ready at a clock edge), load the internal state register with InvShiftRows(in_state) XOR round_key, and capture last.
REQ-014 SHALL use FSM states IDLE, MIX and DONE.
- IDLE: in_ready=1.
- On acceptance, go to DONE if last=1, otherwise go to MIX with column counter 0.
REQ-015 SHALL, in MIX, replace one column per cycle, column counter 0,1,2,3, with InvMixColumns of that column.
- After column 3 is written, the counter wraps to 0 and the FSM goes to DONE.
REQ-016 SHALL compute InvMixColumns with matrix rows {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
- Arithmetic in GF(2^8), reduction polynomial 0x11B.
- Row r of the matrix produces byte r of the column.
REQ-017 SHALL, in DONE, drive out_valid=1 with out_state equal to the state register, holding both stable until out_ready=1.
REQ-018 SHALL, in DONE with out_ready=1, complete the transfer and return to IDLE, with in_ready=1 on the following cycle.
REQ-019 SHALL give latency from acceptance edge to first cycle of out_valid=1 as follows:
- 5 cycles when last=0.
- 1 cycle when last=1.
REQ-020 SHALL drive in_ready=0 in MIX and DONE, so no overlap is possible.
- in_valid, in_state, round_key and last are ignored outside IDLE.
REQ-021 SHALL accept a new input no earlier than the cycle after an output transfer; back-to-back throughput is 1 block per 6 cycles (last=0) or per 2 cycles (last=1).
REQ-022 SHALL, when out_ready is already high as DONE is entered, transfer in that first DONE cycle.
REQ-023 SHALL treat out_ready asserted outside DONE as having no effect.
REQ-024 SHALL drive out_state from a register only, with no combinational path from in_state.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, set FSM=IDLE, column counter=0, state register=0, out_valid=0 and busy=0.
REQ-026 SHALL ignore in_valid while rst=1; in_ready=1 from the first cycle after rst is released.
REQ-027 SHALL abort any block in progress on reset during MIX or DONE, discarding it, with no out_valid pulse afterwards.

Verification
REQ-028 SHALL be covered by an InvShiftRows scenario.
- Stimulus: last=1, key=0, in_state bytes 00..0f (byte b = b).
- Required response: out_state = 000d0a07 04010e0b 0805020f 0c090603, out_valid 1 cycle after acceptance.
REQ-029 SHALL be covered by an InvMixColumns scenario.
- Stimulus: last=0, key=0, every column 8e 4d a1 bc.
- Required response: every output column db 13 53 45, out_valid exactly 5 cycles after acceptance.
REQ-030 SHALL be covered by a second InvMixColumns and AddRoundKey scenario.
- Stimulus: last=0, every column 9f dc 58 9d, key all 00.
- Required response: every column f2 0a 22 5c.
- Repeat with every column c6 c6 c6 c6 and key all ff; required response: every column 39 39 39 39.
REQ-031 SHALL be covered by a backpressure scenario.
- Stimulus: hold out_ready=0 for 10 cycles in DONE.
- Required response: out_valid and out_state stable, in_ready=0.
- Then out_ready=1 for one cycle: IDLE next cycle, and a second block is accepted immediately.
REQ-032 SHALL be covered by a mid-operation reset scenario.
- Stimulus: rst=1 in the MIX cycle for column 2.
- Required response: next cycle out_valid=0, busy=0, out_state=0, in_ready=1.
- A following block with last=1 yields a correct result.
REQ-033 SHALL be covered by a protocol scenario.
- Stimulus: in_valid=1 held continuously, last=0, out_ready=1.
- Required response: acceptances exactly every 6 cycles, each out_valid a single-cycle pulse, no input accepted while busy=1.
